seq_store_ring: RTL and testbench

//  Parametrised sequence capture/store engine for the SeqVerify path. Catches a
//  SEQ_W-bit sequence on each newSequence request and writes it to successive
//  RAM addresses (ring pointer), instead of always writing address 0.

---
 rtl/seq_store_ring_if.sv | 27 ++
 rtl/seq_store_ring.sv | 101 ++++++++++
 tb/tb_seq_store_ring.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_store_ring_if.sv
// Signal bundle between the sequence source, seq_store_ring and the sequence RAM write port.
// master = source/RAM side, slave = seq_store_ring.
interface seq_store_ring_if #(
   parameter int SEQ_W  = 20,
   parameter int ADDR_W = 5
);
   logic              newSequence;
   logic [SEQ_W-1:0]  Sequence;
   logic              clear;
   logic [SEQ_W-1:0]  S_out;
   logic [ADDR_W-1:0] RAM_addr;
   logic              RAM_W;
   logic              busy;
   logic              full;
   logic [ADDR_W:0]   count;
   logic              dropped;

   modport master (
      output newSequence, Sequence, clear,
      input  S_out, RAM_addr, RAM_W, busy, full, count, dropped
   );

   modport slave (
      input  newSequence, Sequence, clear,
      output S_out, RAM_addr, RAM_W, busy, full, count, dropped
   );
endinterface

// File: rtl/seq_store_ring.sv
// Sequence capture/store engine: writes each requested sequence to the next ring slot of the RAM.
// Build option SEQ_STORE_OVERWRITE_EN: when full, overwrite the oldest slot instead of dropping.
module seq_store_ring #(
   parameter int SEQ_W  = 20,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input logic             clk,
   input logic             rst,
   seq_store_ring_if.slave bus
);

   localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

`ifdef SEQ_STORE_OVERWRITE_EN
   localparam bit OVERWRITE = 1'b1;
`else
   localparam bit OVERWRITE = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      CATCH,
      WRITE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [SEQ_W-1:0]  captured;
   logic [ADDR_W-1:0] wr_ptr;
   logic              accept;
   logic              refuse;

   assign accept = bus.newSequence && (!bus.full || OVERWRITE);
   assign refuse = bus.newSequence &&  bus.full && !OVERWRITE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = CATCH;
         CATCH:   state_next = WRITE;
         WRITE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (bus.clear) state_next = IDLE;
   end

   // NOTE: captured has no reset; it is always reloaded in CATCH before WRITE reads it.
   always_ff @(posedge clk) begin
      if (state == CATCH && !bus.clear) captured <= bus.Sequence;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         bus.S_out    <= '0;
         bus.RAM_addr <= '0;
         bus.RAM_W    <= 1'b0;
         bus.busy     <= 1'b0;
         bus.full     <= 1'b0;
         bus.count    <= '0;
         bus.dropped  <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every branch below reads pre-edge register values.
         bus.RAM_W   <= 1'b0;
         bus.dropped <= 1'b0;
         bus.busy    <= (state_next != IDLE);
         if (bus.clear) begin
            // S_out/RAM_addr intentionally keep their last values across a flush.
            wr_ptr    <= '0;
            bus.count <= '0;
            bus.full  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (refuse) bus.dropped <= 1'b1;
               end
               WRITE: begin
                  bus.RAM_W    <= 1'b1;
                  bus.S_out    <= captured;
                  bus.RAM_addr <= wr_ptr;
                  wr_ptr       <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                  if (bus.count != DEPTH_CNT) begin
                     bus.count <= bus.count + 1'b1;
                     bus.full  <= (bus.count + 1'b1 == DEPTH_CNT);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seq_store_ring.sv
// Randomized self-checking bench for seq_store_ring: a 32-slot ring and a 5-slot ring
// checked every cycle against a slot-level reference model.
module tb_seq_store_ring;
   localparam int SEQ_W   = 20;
   localparam int A_AW    = 5;
   localparam int A_DEPTH = 32;
   localparam int B_AW    = 3;
   localparam int B_DEPTH = 5;

   typedef struct packed {
      logic             w;
      logic             busy;
      logic             full;
      logic             drop;
      logic [31:0]      addr;
      logic [31:0]      cnt;
      logic [SEQ_W-1:0] s;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   seq_store_ring_if #(.SEQ_W(SEQ_W), .ADDR_W(A_AW)) bus_a ();
   seq_store_ring_if #(.SEQ_W(SEQ_W), .ADDR_W(B_AW)) bus_b ();

   seq_store_ring #(.SEQ_W(SEQ_W), .ADDR_W(A_AW), .DEPTH(A_DEPTH)) u_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );
   seq_store_ring #(.SEQ_W(SEQ_W), .ADDR_W(B_AW), .DEPTH(B_DEPTH)) u_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

`ifdef SEQ_STORE_OVERWRITE_EN
   bit ovr = 1'b1;
`else
   bit ovr = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int sel      = 0;

   // Reference model: ring position, fill level and last RAM write, per instance.
   int               depth [2] = '{A_DEPTH, B_DEPTH};
   int               m_ptr [2];
   int               m_cnt [2];
   int               m_last_addr [2];
   logic [SEQ_W-1:0] m_last_s [2];

   obs_t o;
   always_comb begin
      if (sel == 0) begin
         o.w    = bus_a.RAM_W;
         o.busy = bus_a.busy;
         o.full = bus_a.full;
         o.drop = bus_a.dropped;
         o.addr = 32'(bus_a.RAM_addr);
         o.cnt  = 32'(bus_a.count);
         o.s    = bus_a.S_out;
      end else begin
         o.w    = bus_b.RAM_W;
         o.busy = bus_b.busy;
         o.full = bus_b.full;
         o.drop = bus_b.dropped;
         o.addr = 32'(bus_b.RAM_addr);
         o.cnt  = 32'(bus_b.count);
         o.s    = bus_b.S_out;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic select(input int s);
      sel = s;
      #1;
   endtask

   task automatic drive(input logic req, input logic [SEQ_W-1:0] d, input logic clr);
      if (sel == 0) begin
         bus_a.newSequence = req;
         bus_a.Sequence    = d;
         bus_a.clear       = clr;
      end else begin
         bus_b.newSequence = req;
         bus_b.Sequence    = d;
         bus_b.clear       = clr;
      end
   endtask

   task automatic model_reset_all();
      for (int i = 0; i < 2; i++) begin
         m_ptr[i]       = 0;
         m_cnt[i]       = 0;
         m_last_addr[i] = 0;
         m_last_s[i]    = '0;
      end
   endtask

   task automatic model_write(input logic [SEQ_W-1:0] d);
      m_last_addr[sel] = m_ptr[sel];
      m_last_s[sel]    = d;
      m_ptr[sel]       = (m_ptr[sel] + 1) % depth[sel];
      if (m_cnt[sel] < depth[sel]) m_cnt[sel]++;
   endtask

   function automatic obs_t idle_exp();
      obs_t e;
      e.w    = 1'b0;
      e.busy = 1'b0;
      e.drop = 1'b0;
      e.full = (m_cnt[sel] == depth[sel]);
      e.addr = 32'(m_last_addr[sel]);
      e.cnt  = 32'(m_cnt[sel]);
      e.s    = m_last_s[sel];
      return e;
   endfunction

   // One store request with per-cycle expectations from request edge N through N+3.
   task automatic store(input string tag, input logic [SEQ_W-1:0] d);
      obs_t exp;
      bit   take;
      take = (m_cnt[sel] < depth[sel]) || ovr;
      drive(1'b1, d, 1'b0);
      tick;
      drive(1'b0, d, 1'b0);
      exp      = idle_exp();
      exp.busy = take;
      exp.drop = !take;
      n_checks++;
      if (o !== exp) begin
         n_fail++;
         $display("FAIL %s edge N: got %p required %p", tag, o, exp);
      end
      tick;
      drive(1'b0, ~d, 1'b0);
      exp      = idle_exp();
      exp.busy = take;
      n_checks++;
      if (o !== exp) begin
         n_fail++;
         $display("FAIL %s edge N+1: got %p required %p", tag, o, exp);
      end
      tick;
      if (take) model_write(d);
      exp   = idle_exp();
      exp.w = take;
      n_checks++;
      if (o !== exp) begin
         n_fail++;
         $display("FAIL %s edge N+2: got %p required %p", tag, o, exp);
      end
      tick;
      exp = idle_exp();
      n_checks++;
      if (o !== exp) begin
         n_fail++;
         $display("FAIL %s edge N+3: got %p required %p", tag, o, exp);
      end
   endtask

   task automatic do_clear(input string tag);
      obs_t exp;
      drive(1'b0, '0, 1'b1);
      tick;
      drive(1'b0, '0, 1'b0);
      m_ptr[sel] = 0;
      m_cnt[sel] = 0;
      exp = idle_exp();
      n_checks++;
      if (o !== exp) begin
         n_fail++;
         $display("FAIL %s clear: got %p required %p", tag, o, exp);
      end
   endtask

   task automatic test_reset();
      obs_t exp;
      for (int s = 0; s < 2; s++) begin
         select(s);
         drive(1'b0, '0, 1'b0);
      end
      model_reset_all();
      #12;
      for (int s = 0; s < 2; s++) begin
         select(s);
         exp = idle_exp();
         n_checks++;
         if (o !== exp) begin
            n_fail++;
            $display("FAIL reset_held inst%0d: got %p required %p", s, o, exp);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      tick;
      tick;
      for (int s = 0; s < 2; s++) begin
         select(s);
         exp = idle_exp();
         n_checks++;
         if (o !== exp) begin
            n_fail++;
            $display("FAIL reset_released inst%0d: got %p required %p", s, o, exp);
         end
      end
   endtask

   task automatic test_single_store();
      select(0);
      store("single_abcde", 20'hABCDE);
   endtask

   task automatic test_fill_and_full();
      select(0);
      do_clear("fill_pre");
      for (int i = 0; i < A_DEPTH; i++) begin
         store("fill", SEQ_W'(i) | SEQ_W'($urandom << A_AW));
         repeat ($urandom_range(0, 2)) tick;
      end
      store("fill_extra", SEQ_W'($urandom));
      store("fill_extra2", SEQ_W'($urandom));
      do_clear("fill_post");
   endtask

   // newSequence held for 6 edges: requests at edges 1 and 4 are taken, writes after edges 3 and 6.
   task automatic test_hold_request();
      logic [SEQ_W-1:0] data [10];
      obs_t             exp;
      select(0);
      do_clear("hold_pre");
      for (int c = 0; c < 10; c++) data[c] = SEQ_W'($urandom);
      for (int c = 1; c <= 9; c++) begin
         drive(c <= 6, data[c], 1'b0);
         tick;
         if (c == 3 || c == 6) model_write(data[c-1]);
         exp      = idle_exp();
         exp.busy = (c == 1 || c == 2 || c == 4 || c == 5);
         exp.w    = (c == 3 || c == 6);
         n_checks++;
         if (o !== exp) begin
            n_fail++;
            $display("FAIL hold cycle%0d: got %p required %p", c, o, exp);
         end
      end
      drive(1'b0, '0, 1'b0);
   endtask

   task automatic test_clear_in_catch();
      obs_t             exp;
      logic [SEQ_W-1:0] d;
      select(0);
      store("clr_prep0", SEQ_W'($urandom));
      store("clr_prep1", SEQ_W'($urandom));
      d = SEQ_W'($urandom);
      drive(1'b1, d, 1'b0);
      tick;
      drive(1'b0, d, 1'b1);
      tick;
      drive(1'b0, d, 1'b0);
      m_ptr[sel] = 0;
      m_cnt[sel] = 0;
      for (int c = 0; c < 3; c++) begin
         exp = idle_exp();
         n_checks++;
         if (o !== exp) begin
            n_fail++;
            $display("FAIL clear_catch cycle%0d: got %p required %p", c, o, exp);
         end
         tick;
      end
      store("clr_after", SEQ_W'($urandom));
   endtask

   task automatic test_reset_mid_op();
      obs_t exp;
      select(0);
      store("rst_prep", SEQ_W'($urandom));
      drive(1'b1, SEQ_W'($urandom), 1'b0);
      tick;
      drive(1'b0, '0, 1'b0);
      tick;
      #2 rst = 1'b0;
      #1;
      model_reset_all();
      exp = idle_exp();
      n_checks++;
      if (o !== exp) begin
         n_fail++;
         $display("FAIL reset_in_write_state: got %p required %p", o, exp);
      end
      @(negedge clk);
      rst = 1'b1;
      tick;
      store("rst_prep2", SEQ_W'($urandom));
      drive(1'b1, 20'h12345, 1'b0);
      tick;
      drive(1'b0, 20'h12345, 1'b0);
      tick;
      tick;
      model_write(20'h12345);
      exp   = idle_exp();
      exp.w = 1'b1;
      n_checks++;
      if (o !== exp) begin
         n_fail++;
         $display("FAIL reset_pre_pulse: got %p required %p", o, exp);
      end
      #2 rst = 1'b0;
      #1;
      model_reset_all();
      exp = idle_exp();
      n_checks++;
      if (o !== exp) begin
         n_fail++;
         $display("FAIL reset_during_pulse: got %p required %p", o, exp);
      end
      @(negedge clk);
      rst = 1'b1;
      tick;
   endtask

   task automatic test_small_ring();
      select(1);
      do_clear("small_pre");
      for (int i = 0; i < 7; i++) store("small_ring", SEQ_W'($urandom));
   endtask

   task automatic test_random_mix();
      int op;
      obs_t exp;
      select(1);
      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(0, 9));
         if (op < 7) begin
            store("rand_store", SEQ_W'($urandom));
         end else if (op == 7) begin
            do_clear("rand_clear");
         end else begin
            tick;
            exp = idle_exp();
            n_checks++;
            if (o !== exp) begin
               n_fail++;
               $display("FAIL rand_idle: got %p required %p", o, exp);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_store();
      test_fill_and_full();
      test_hold_request();
      test_clear_in_catch();
      test_reset_mid_op();
      test_small_ring();
      test_random_mix();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
